alu_result_disp: RTL and testbench

//  Downstream display stage for the 4-bit ALU add/sub datapath. Captures a result

---
 rtl/alu_result_disp_pkg.sv | 29 ++
 rtl/alu_result_disp_seg7_mag_dec.sv | 25 ++
 rtl/alu_result_disp.sv | 121 ++++++++++++
 tb/tb_alu_result_disp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_disp_pkg.sv
// Shared definitions for the ALU result display stage: active-low 7-seg codes,
// FSM state encoding and the two's-complement magnitude helper.
package alu_result_disp_pkg;

  // Segment order is {a,b,c,d,e,f,g,dp}, a 0 lights the segment.
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_MINUS = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SHOW = 2'd2
  } state_t;

  // 4-bit negate without saturation, so -8 (4'b1000) yields 8.
  function automatic logic [3:0] abs4(input logic [3:0] v);
    return v[3] ? (~v + 4'd1) : v;
  endfunction

endpackage

// File: rtl/alu_result_disp_seg7_mag_dec.sv
// Magnitude decoder: 0..8 to an active-low 7-seg code; anything above 8 is blank.
module seg7_mag_dec
  import alu_result_disp_pkg::*;
(
  input  logic [3:0] mag,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (mag)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_disp.sv
// Display stage for the 4-bit add/sub ALU: captures a result on valid/ready,
// holds it for MIN_HOLD cycles and shows sign + magnitude, blinking on overflow.
module alu_result_disp
  import alu_result_disp_pkg::*;
#(
  parameter int MIN_HOLD  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [3:0] res,
  input  logic       cout,
  input  logic       overflow,
  output logic [7:0] seg_sign,
  output logic [7:0] seg_mag,
  output logic [1:0] led
);

  localparam int HOLD_W  = (MIN_HOLD  > 1) ? $clog2(MIN_HOLD)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MIN_HOLD - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Handshake: a transfer happens in any cycle where res_valid & res_ready.
  // res_ready is a pure function of state; upstream holds res_valid and data
  // stable until the transfer.
  state_t             state;
  state_t             state_next;
  logic               accept;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [3:0]         held_res;
  logic               held_cout;
  logic               held_ov;
  logic [3:0]         mag;
  logic [7:0]         mag_code;

  assign res_ready = (state != HOLD);
  assign accept    = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = HOLD;
      HOLD:    if (hold_cnt == HOLD_LAST) state_next = SHOW;
      SHOW:    if (accept) state_next = HOLD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (accept) begin
      hold_cnt <= '0;
    end else if (state == HOLD && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_res  <= '0;
      held_cout <= 1'b0;
      held_ov   <= 1'b0;
    end else if (accept) begin
      held_res  <= res;
      held_cout <= cout;
      held_ov   <= overflow;
    end
  end

  // Blink timebase only runs while the held result overflowed; a new accept
  // restarts it in the visible phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (accept) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (held_ov) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign mag = abs4(held_res);

  seg7_mag_dec u_mag_dec (
    .mag (mag),
    .seg (mag_code)
  );

  always_comb begin
    seg_sign = SEG_BLANK;
    seg_mag  = SEG_BLANK;
    if (state != IDLE && !(held_ov && blink_phase)) begin
      seg_sign = held_res[3] ? SEG_MINUS : SEG_BLANK;
      seg_mag  = mag_code;
    end
  end

  assign led = {held_cout, held_ov};

endmodule

// File: tb/tb_alu_result_disp.sv
// Bench for alu_result_disp: directed scenarios plus random traffic, checked
// against a timestamp-based model of the displayed value.
module tb_alu_result_disp;

  localparam int MIN_HOLD  = 4;
  localparam int BLINK_DIV = 8;

  logic       clk;
  logic       rst_n;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res;
  logic       cout;
  logic       overflow;
  logic [7:0] seg_sign;
  logic [7:0] seg_mag;
  logic [1:0] led;

  alu_result_disp #(.MIN_HOLD(MIN_HOLD), .BLINK_DIV(BLINK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .cout      (cout),
    .overflow  (overflow),
    .seg_sign  (seg_sign),
    .seg_mag   (seg_mag),
    .led       (led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // model: what was last accepted and how many edges ago
  logic [7:0] code_tab [0:8];
  logic       m_have;
  logic [3:0] m_res;
  logic       m_cout;
  logic       m_ov;
  int         m_elapsed;
  logic       last_accept;

  // scoreboard
  logic [18:0] exp_q[$];
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic m_ready();
    return !m_have || (m_elapsed >= MIN_HOLD);
  endfunction

  // {res_ready, led[1:0], seg_sign, seg_mag}
  function automatic logic [18:0] model_out();
    int v;
    int mag;
    logic blank;
    logic [7:0] s_sign;
    logic [7:0] s_mag;
    if (!m_have) return {1'b1, 2'b00, 8'hFF, 8'hFF};
    v     = m_res[3] ? int'(m_res) - 16 : int'(m_res);
    mag   = (v < 0) ? -v : v;
    blank = m_ov && (((m_elapsed / BLINK_DIV) % 2) == 1);
    s_sign = blank ? 8'hFF : ((v < 0) ? 8'hFD : 8'hFF);
    s_mag  = blank ? 8'hFF : code_tab[mag];
    return {m_ready(), m_cout, m_ov, s_sign, s_mag};
  endfunction

  task automatic compare_all();
    logic [18:0] e;
    exp_q.push_back(model_out());
    e = exp_q.pop_front();
    check("res_ready", 32'(res_ready), 32'(e[18]));
    check("led",       32'(led),       32'(e[17:16]));
    check("seg_sign",  32'(seg_sign),  32'(e[15:8]));
    check("seg_mag",   32'(seg_mag),   32'(e[7:0]));
  endtask

  // driver tasks
  task automatic step();
    logic acc;
    acc = res_valid && m_ready();
    @(posedge clk);
    if (acc) begin
      m_have    = 1'b1;
      m_res     = res;
      m_cout    = cout;
      m_ov      = overflow;
      m_elapsed = 0;
    end else begin
      m_elapsed++;
    end
    last_accept = acc;
    #1;
    compare_all();
  endtask

  task automatic send(input logic [3:0] r, input logic c, input logic o, output int waited);
    res       = r;
    cout      = c;
    overflow  = o;
    res_valid = 1'b1;
    waited    = 0;
    do begin
      step();
      waited++;
    end while (!last_accept && waited < 50);
    if (!last_accept) check("send_timeout", 32'd0, 32'd1);
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_have    = 1'b0;
    m_elapsed = 0;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int waited;
    int lows;
    code_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01};
    n_checks  = 0;
    n_pass    = 0;
    m_have    = 1'b0;
    m_res     = '0;
    m_cout    = 1'b0;
    m_ov      = 1'b0;
    m_elapsed = 0;
    last_accept = 1'b0;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res       = '0;
    cout      = 1'b0;
    overflow  = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    compare_all();
    check("rst_sign", 32'(seg_sign), 32'hFF);
    check("rst_ready", 32'(res_ready), 32'd1);

    // +5, then count the hold window
    send(4'b0101, 1'b0, 1'b0, waited);
    check("t2_sign", 32'(seg_sign), 32'hFF);
    check("t2_mag",  32'(seg_mag),  32'h49);
    lows = (res_ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (res_ready == 1'b0) lows++;
    end
    check("t2_hold_cycles", 32'(lows), 32'(MIN_HOLD));

    // -3 then -8
    send(4'b1101, 1'b0, 1'b0, waited);
    check("t3_sign", 32'(seg_sign), 32'hFD);
    check("t3_mag",  32'(seg_mag),  32'h0D);

    // valid held through HOLD: ignored until SHOW
    send(4'b0001, 1'b1, 1'b0, waited);
    check("t4_wait", 32'(waited), 32'(MIN_HOLD + 1));
    check("t4_mag",  32'(seg_mag), 32'h9F);

    repeat (MIN_HOLD) step();
    send(4'b1000, 1'b0, 1'b0, waited);
    check("t3_min_sign", 32'(seg_sign), 32'hFD);
    check("t3_min_mag",  32'(seg_mag),  32'h01);

    // overflow blink
    repeat (MIN_HOLD) step();
    send(4'b0111, 1'b1, 1'b1, waited);
    check("t5_led", 32'(led), 32'h3);
    check("t5_mag", 32'(seg_mag), 32'h1F);
    repeat (BLINK_DIV) step();
    check("t5_blank", 32'(seg_mag), 32'hFF);
    repeat (3 * BLINK_DIV) step();

    // reset mid-HOLD while blinking
    send(4'b1010, 1'b1, 1'b1, waited);
    repeat (2) step();
    do_reset();
    check("t6_ready", 32'(res_ready), 32'd1);
    check("t6_led",   32'(led), 32'd0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      res_valid = 1'($urandom_range(0, 1));
      res       = 4'($urandom);
      cout      = 1'($urandom_range(0, 1));
      overflow  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end
    res_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
